fft_pingpong_bitrev_ctrl: RTL and testbench

- Controller that sequences one simple dual-port RAM (registered read, 1-cycle read latency) as a two-bank ping-pong reorder buffer for the FFT datapath.
- Input samples are written in natural order into one bank.
- The other bank is read out in bit-reversed order as an output stream.
- Sits between a radix stage output and the next stage or output interface; the RAM instance is external, and this block drives its ports.

---
 rtl/fft_mem_pkg.sv | 18 +
 rtl/fft_out_skid2.sv | 53 +++++
 rtl/fft_pingpong_bitrev_ctrl.sv | 114 +++++++++++
 tb/tb_fft_pingpong_bitrev_ctrl.sv | 321 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fft_mem_pkg.sv
// Shared types and helpers for the FFT reorder-buffer memory controllers.
package fft_mem_pkg;

  typedef enum logic {BANK_EMPTY = 1'b0, BANK_FULL = 1'b1} bank_st_e;

  // Mirrors the low w bits of v (w <= 32); bits at and above w must be zero.
  // The full 32-bit word is reversed, then shifted down so the mirrored field
  // lands back at bit 0. With a constant w this reduces to pure wiring.
  function automatic logic [31:0] bitrev(input logic [31:0] v, input int unsigned w);
    logic [31:0] r;
    r = '0;
    for (int i = 0; i < 32; i++) begin
      r[i] = v[31-i];
    end
    return r >> (32 - w);
  endfunction

endpackage

// File: rtl/fft_out_skid2.sv
// Two-entry FIFO with valid/ready on both sides. It absorbs the one-cycle
// RAM read latency so the read issue logic can run at full rate while the
// output handshake is registered-friendly.
module fft_out_skid2 #(
  parameter int W = 11
) (
  input  logic         clk,
  input  logic         rstn,
  input  logic         s_valid,
  input  logic [W-1:0] s_data,
  output logic         s_ready,
  output logic         m_valid,
  output logic [W-1:0] m_data,
  input  logic         m_ready,
  output logic [1:0]   cnt
);

  logic [W-1:0] mem [2];
  logic         wr_ptr;
  logic         rd_ptr;
  logic         push;
  logic         pop;

  // A full FIFO can still accept when the head leaves in the same cycle.
  assign s_ready = (cnt != 2'd2) | m_ready;
  assign m_valid = (cnt != 2'd0);
  assign m_data  = mem[rd_ptr];
  assign push    = s_valid & s_ready;
  assign pop     = m_valid & m_ready;

  // Occupancy and pointer bookkeeping.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      cnt    <= 2'd0;
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
    end else begin
      if (push) wr_ptr <= ~wr_ptr;
      if (pop)  rd_ptr <= ~rd_ptr;
      unique case ({push, pop})
        2'b10:   cnt <= cnt + 2'd1;
        2'b01:   cnt <= cnt - 2'd1;
        default: cnt <= cnt;
      endcase
    end
  end

  // Entry storage; contents are don't-care while the entry is not occupied.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= s_data;
  end

endmodule

// File: rtl/fft_pingpong_bitrev_ctrl.sv
// Ping-pong reorder controller: one external simple dual-port RAM split into
// two banks by the address MSB. Samples are written in natural order into the
// write bank while the other bank is read back in bit-reversed order.
module fft_pingpong_bitrev_ctrl
  import fft_mem_pkg::*;
#(
  parameter  int D_WIDTH = 10,
  parameter  int N_LOG2  = 8,
  localparam int A_WIDTH = N_LOG2 + 1
) (
  input  logic               clk,
  input  logic               rstn,
  input  logic               in_valid,
  input  logic [D_WIDTH-1:0] in_data,
  output logic               in_ready,
  output logic               out_valid,
  output logic [D_WIDTH-1:0] out_data,
  output logic               out_last,
  input  logic               out_ready,
  output logic [A_WIDTH-1:0] mem_waddr,
  output logic [D_WIDTH-1:0] mem_wdata,
  output logic               mem_wen,
  output logic [A_WIDTH-1:0] mem_raddr,
  input  logic [D_WIDTH-1:0] mem_rdata
);

  localparam logic [N_LOG2-1:0] CNT_LAST = '1;

  bank_st_e          bank_st [2];
  logic              wr_bank;
  logic [N_LOG2-1:0] wr_cnt;
  logic              rd_bank;
  logic [N_LOG2-1:0] rd_cnt;
  logic              rd_pend;
  logic              pend_last;

  logic              wr_acc;
  logic              wr_done;
  logic              issue;
  logic              rd_done;
  logic              pop;
  logic [1:0]        fifo_cnt;
  logic [2:0]        occ;
  logic [N_LOG2-1:0] rd_cnt_rev;
  logic              skid_ready;
  logic [D_WIDTH:0]  skid_out;

  // Write side: natural-order addressing into the current write bank.
  assign in_ready  = rstn & (bank_st[wr_bank] == BANK_EMPTY);
  assign wr_acc    = in_valid & in_ready;
  assign wr_done   = wr_acc & (wr_cnt == CNT_LAST);
  assign mem_wen   = wr_acc;
  assign mem_waddr = {wr_bank, wr_cnt};
  assign mem_wdata = in_data;

  // Read side: issue only while the FIFO plus the in-flight read leave room
  // for the word that will land next cycle, counting a pop happening now.
  assign pop        = out_valid & out_ready;
  assign occ        = {1'b0, fifo_cnt} + {2'b00, rd_pend};
  assign issue      = (bank_st[rd_bank] == BANK_FULL) & (occ <= ({2'b00, pop} + 3'd1));
  assign rd_done    = issue & (rd_cnt == CNT_LAST);
  assign rd_cnt_rev = N_LOG2'(bitrev(32'(rd_cnt), N_LOG2));
  assign mem_raddr  = {rd_bank, rd_cnt_rev};

  // Bank ownership, counters and the read-pending flag. A write-side fill and
  // a read-side drain in the same cycle always target different banks.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      bank_st[0] <= BANK_EMPTY;
      bank_st[1] <= BANK_EMPTY;
      wr_bank    <= 1'b0;
      wr_cnt     <= '0;
      rd_bank    <= 1'b0;
      rd_cnt     <= '0;
      rd_pend    <= 1'b0;
    end else begin
      if (wr_acc) wr_cnt <= wr_cnt + 1'b1;
      if (wr_done) begin
        bank_st[wr_bank] <= BANK_FULL;
        wr_bank          <= ~wr_bank;
      end
      if (issue) rd_cnt <= rd_cnt + 1'b1;
      if (rd_done) begin
        bank_st[rd_bank] <= BANK_EMPTY;
        rd_bank          <= ~rd_bank;
      end
      rd_pend <= issue;
    end
  end

  // Frame-end tag travelling with the read that is in flight.
  always_ff @(posedge clk) begin
    if (issue) pend_last <= (rd_cnt == CNT_LAST);
  end

  // Stage boundary: RAM read data returns one cycle after issue and is queued.
  fft_out_skid2 #(
    .W (D_WIDTH + 1)
  ) u_skid (
    .clk     (clk),
    .rstn    (rstn),
    .s_valid (rd_pend & skid_ready),
    .s_data  ({mem_rdata, pend_last}),
    .s_ready (skid_ready),
    .m_valid (out_valid),
    .m_data  (skid_out),
    .m_ready (out_ready),
    .cnt     (fifo_cnt)
  );

  assign out_data = skid_out[D_WIDTH:1];
  assign out_last = out_valid & skid_out[0];

endmodule

// File: tb/tb_fft_pingpong_bitrev_ctrl.sv
// Directed bench for the ping-pong bit-reverse controller (N_LOG2=3, D_WIDTH=10).
module tb_fft_pingpong_bitrev_ctrl;

  localparam int DW = 10;
  localparam int NL = 3;
  localparam int AW = NL + 1;

  logic          clk = 1'b0;
  logic          rstn;
  logic          in_valid;
  logic [DW-1:0] in_data;
  logic          in_ready;
  logic          out_valid;
  logic [DW-1:0] out_data;
  logic          out_last;
  logic          out_ready;
  logic [AW-1:0] mem_waddr;
  logic [DW-1:0] mem_wdata;
  logic          mem_wen;
  logic [AW-1:0] mem_raddr;
  logic [DW-1:0] mem_rdata;

  fft_pingpong_bitrev_ctrl #(.D_WIDTH(DW), .N_LOG2(NL)) dut (
    .clk       (clk),
    .rstn      (rstn),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_ready  (in_ready),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_last  (out_last),
    .out_ready (out_ready),
    .mem_waddr (mem_waddr),
    .mem_wdata (mem_wdata),
    .mem_wen   (mem_wen),
    .mem_raddr (mem_raddr),
    .mem_rdata (mem_rdata)
  );

  always #5 clk = ~clk;

  // External RAM model: registered read, one-cycle latency.
  logic [DW-1:0] ram [16];
  always @(posedge clk) begin
    if (mem_wen) ram[mem_waddr] <= mem_wdata;
    mem_rdata <= ram[mem_raddr];
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int total = 0;
  int bad   = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  typedef struct {
    logic [DW-1:0] d;
    logic          l;
    int            c;
  } got_t;
  got_t got[$];

  typedef struct {
    logic [DW-1:0] din;
    logic [DW-1:0] exp_dout;
    logic          exp_last;
  } vec_t;
  vec_t tab [8];
  int   br  [8];

  logic          hold_v = 1'b0;
  logic [DW-1:0] hold_d;
  logic          hold_l;
  int            last_acc_cyc = 0;
  int            stall_cnt = 0;
  bit            chk_fifo = 1'b0;

  // Output collector, handshake-edge bookkeeping and stall-stability checks.
  always @(negedge clk) begin
    if (rstn) begin
      if (hold_v) begin
        chk("hold_valid", 32'(out_valid), 32'd1);
        chk("hold_data", 32'(out_data), 32'(hold_d));
        chk("hold_last", 32'(out_last), 32'(hold_l));
      end
      hold_v <= out_valid && !out_ready;
      hold_d <= out_data;
      hold_l <= out_last;
      if (out_valid && out_ready) got.push_back('{out_data, out_last, cyc + 1});
      if (in_valid && in_ready) last_acc_cyc <= cyc + 1;
      if (in_valid && !in_ready) stall_cnt <= stall_cnt + 1;
      if (chk_fifo) chk("fifo_cnt_le2", 32'(dut.fifo_cnt <= 2'd2), 32'd1);
    end else begin
      hold_v <= 1'b0;
    end
  end

  task automatic send(input int d);
    int t;
    t = 0;
    in_valid = 1'b1;
    in_data  = DW'(d);
    @(negedge clk);
    while (!in_ready && t < 200) begin
      @(negedge clk);
      t++;
    end
    if (!in_ready) chk("send_timeout", 32'(in_ready), 32'd1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1;
    rstn     = 1'b0;
    in_valid = 1'b0;
    @(posedge clk);
    #1;
    rstn = 1'b1;
  endtask

  task automatic wait_got(input int n, input string nm);
    int t;
    t = 0;
    while (got.size() < n && t < 400) begin
      @(posedge clk);
      t++;
    end
    repeat (3) @(posedge clk);
    #1;
    chk({nm, "_count"}, 32'(got.size()), 32'(n));
  endtask

  task automatic chk_frames(input int n, input int base, input string nm);
    for (int k = 0; k < n; k++) begin
      if (k < got.size()) begin
        chk({nm, "_data"}, 32'(got[k].d), 32'(base + (k / 8) * 8 + br[k % 8]));
        chk({nm, "_last"}, 32'(got[k].l), 32'((k % 8) == 7));
      end
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int e0;
    int s0;
    int rel;
    int ri;
    int t;
    br = '{0, 4, 2, 6, 1, 5, 3, 7};
    for (int i = 0; i < 8; i++) begin
      tab[i].din      = DW'(i);
      tab[i].exp_dout = DW'(br[i]);
      tab[i].exp_last = (i == 7);
    end

    rstn      = 1'b0;
    in_valid  = 1'b0;
    in_data   = '0;
    out_ready = 1'b0;

    // Reset state, with a sample offered while reset is held.
    repeat (2) @(posedge clk);
    #1;
    in_valid = 1'b1;
    in_data  = 10'd5;
    #1;
    chk("rst_in_ready", 32'(in_ready), 32'd0);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_last", 32'(out_last), 32'd0);
    chk("rst_mem_wen", 32'(mem_wen), 32'd0);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    rstn     = 1'b1;
    #1;
    chk("post_rst_in_ready", 32'(in_ready), 32'd1);
    chk("post_rst_out_valid", 32'(out_valid), 32'd0);

    // Single frame from the vector table.
    out_ready = 1'b1;
    got.delete();
    for (int i = 0; i < 8; i++) send(int'(tab[i].din));
    e0 = last_acc_cyc;
    wait_got(8, "single");
    for (int i = 0; i < 8; i++) begin
      if (i < got.size()) begin
        chk("single_data", 32'(got[i].d), 32'(tab[i].exp_dout));
        chk("single_last", 32'(got[i].l), 32'(tab[i].exp_last));
      end
    end
    if (got.size() > 0) chk("single_latency", 32'(got[0].c - e0), 32'd3);

    // Continuous stream of three frames, no bank reset in between.
    got.delete();
    s0 = stall_cnt;
    for (int i = 0; i < 24; i++) send(i);
    chk("stream_no_stall", 32'(stall_cnt - s0), 32'd0);
    wait_got(24, "stream");
    chk_frames(24, 0, "stream");
    if (got.size() == 24) chk("stream_no_bubble", 32'(got[23].c - got[0].c), 32'd23);

    // Backpressure: both banks fill, reads freeze after two issues.
    out_ready = 1'b0;
    do_reset();
    got.delete();
    for (int i = 0; i < 16; i++) send(500 + i);
    #1;
    chk("bp_in_ready_low", 32'(in_ready), 32'd0);
    repeat (3) @(posedge clk);
    #1;
    chk("bp_out_valid", 32'(out_valid), 32'd1);
    chk("bp_out_data", 32'(out_data), 32'd500);
    chk("bp_out_last", 32'(out_last), 32'd0);
    chk("bp_raddr", 32'(mem_raddr), 32'd2);
    chk("bp_in_ready_held", 32'(in_ready), 32'd0);
    repeat (3) @(posedge clk);
    #1;
    chk("bp_raddr_frozen", 32'(mem_raddr), 32'd2);
    chk("bp_no_output", 32'(got.size()), 32'd0);
    out_ready = 1'b1;
    rel = cyc + 1;
    ri  = -1;
    t   = 0;
    while (ri < 0 && t < 50) begin
      @(negedge clk);
      if (in_ready) ri = cyc;
      t++;
    end
    chk("bp_in_ready_return", 32'(ri - rel), 32'd5);
    wait_got(16, "bp");
    chk_frames(16, 500, "bp");

    // Random downstream backpressure over ten frames.
    do_reset();
    got.delete();
    chk_fifo = 1'b1;
    fork
      begin
        for (int i = 0; i < 80; i++) send(300 + i);
      end
      begin
        for (int k = 0; k < 3000 && got.size() < 80; k++) begin
          @(posedge clk);
          #1;
          out_ready = 1'($urandom_range(0, 1));
        end
        out_ready = 1'b1;
      end
    join
    wait_got(80, "rand");
    chk_frames(80, 300, "rand");
    chk_fifo = 1'b0;

    // Reset in the middle of writing a frame.
    out_ready = 1'b1;
    do_reset();
    for (int i = 0; i < 5; i++) send(900 + i);
    rstn     = 1'b0;
    in_valid = 1'b1;
    in_data  = 10'd999;
    #1;
    chk("midrst_in_ready", 32'(in_ready), 32'd0);
    chk("midrst_mem_wen", 32'(mem_wen), 32'd0);
    @(posedge clk);
    #1;
    chk("midrst_in_ready_after", 32'(in_ready), 32'd0);
    chk("midrst_out_valid", 32'(out_valid), 32'd0);
    in_valid = 1'b0;
    rstn     = 1'b1;
    got.delete();
    for (int i = 0; i < 8; i++) send(100 + i);
    wait_got(8, "midrst");
    chk_frames(8, 100, "midrst");

    // Reset while output data is waiting.
    out_ready = 1'b0;
    do_reset();
    for (int i = 0; i < 8; i++) send(700 + i);
    repeat (4) @(posedge clk);
    #1;
    chk("rdrst_out_valid_before", 32'(out_valid), 32'd1);
    rstn = 1'b0;
    @(posedge clk);
    #1;
    chk("rdrst_out_valid", 32'(out_valid), 32'd0);
    chk("rdrst_out_last", 32'(out_last), 32'd0);
    rstn = 1'b1;
    #1;
    chk("rdrst_in_ready", 32'(in_ready), 32'd1);
    out_ready = 1'b1;
    got.delete();
    repeat (10) @(posedge clk);
    #1;
    chk("rdrst_no_stale", 32'(got.size()), 32'd0);
    got.delete();
    s0 = stall_cnt;
    for (int i = 0; i < 16; i++) send(40 + i);
    chk("rdrst_both_empty", 32'(stall_cnt - s0), 32'd0);
    wait_got(16, "rdrst");
    chk_frames(16, 40, "rdrst");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
